// File: rtl/auth_table_ctrl.sv
// auth_table_ctrl: credential table with login/session/account commands and a held failed-login alarm.
// Latency: rejected, LOGOUT and SET_OWN_PW respond 1 cycle after accept; table ops respond MAX_USERS+1 cycles after.
// Backpressure: cmd_ready only in IDLE; with LOCKOUT_TIMER_EN an alarm also holds cmd_ready low for LOCKOUT_CYCLES.
module auth_table_ctrl #(
    parameter int DIGIT_W        = 4,
    parameter int DIGITS         = 4,
    parameter int MAX_USERS      = 8,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter logic [DIGIT_W*DIGITS-1:0] ADMIN_NAME = 16'h1100,
    parameter logic [DIGIT_W*DIGITS-1:0] ADMIN_PASS = 16'h1100
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [2:0]                       cmd_op,
    input  logic [DIGIT_W*DIGITS-1:0]        cmd_user,
    input  logic [DIGIT_W*DIGITS-1:0]        cmd_pass,
    input  logic [1:0]                       cmd_mode,
    output logic                             rsp_valid,
    output logic                             rsp_ok,
    output logic [2:0]                       rsp_code,
    output logic                             locked,
    output logic [$clog2(MAX_USERS)-1:0]     cur_idx,
    output logic [1:0]                       cur_mode,
    output logic [$clog2(MAX_USERS+1)-1:0]   user_count,
    output logic                             alarm,
    input  logic                             alarm_ack,
    output logic                             lockout
);
    localparam int CRED_W = DIGIT_W * DIGITS;
    localparam int IDX_W  = $clog2(MAX_USERS);
    localparam int CNT_W  = $clog2(MAX_USERS + 1);
    localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [2:0] OP_LOGIN = 3'd0, OP_LOGOUT = 3'd1, OP_SETPW = 3'd2,
                           OP_ADD   = 3'd3, OP_CHANGE = 3'd4, OP_DELETE = 3'd5;
    localparam logic [2:0] RC_OK = 3'd0, RC_BAD_PASS = 3'd1, RC_NO_USER = 3'd2, RC_NOT_PERM = 3'd3,
                           RC_FULL = 3'd4, RC_DUP = 3'd5, RC_PROT = 3'd6, RC_BAD_OP = 3'd7;

`ifdef LOCKOUT_TIMER_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP, ST_LOCKOUT} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} state_t;
`endif

    state_t state, state_nx;

    logic [CRED_W-1:0] tbl_name [MAX_USERS];
    logic [CRED_W-1:0] tbl_pass [MAX_USERS];
    logic [1:0]        tbl_mode [MAX_USERS];
    logic [MAX_USERS-1:0] tbl_vld;

    logic [2:0]        op_q;
    logic [CRED_W-1:0] user_q, pass_q;
    logic [1:0]        mode_q;
    logic [2:0]        code_q;
    logic [IDX_W-1:0]  scan_idx, hit_idx_q, free_idx_q;
    logic              hit_q, hit_pw_q, free_q;
    logic [ATT_W-1:0]  attempts;

    logic              accept, imm_scan, scan_hit, scan_last, scan_done;
    logic              fin_hit, fin_pw, fin_free, alarm_set;
    logic [IDX_W-1:0]  fin_idx, fin_free_idx;
    logic [2:0]        imm_code, fin_code;

    assign accept = cmd_valid && cmd_ready;

    // Command screening at acceptance: anything that needs no table search is resolved here.
    always_comb begin
        imm_scan = 1'b0;
        imm_code = RC_OK;
        if (cmd_op > OP_DELETE)                                 imm_code = RC_BAD_OP;
        else if (locked && cmd_op != OP_LOGIN)                  imm_code = RC_NOT_PERM;
        else if (!locked && cmd_op == OP_LOGIN)                 imm_code = RC_NOT_PERM;
        else if (cmd_op == OP_SETPW && cur_mode == 2'd2)        imm_code = RC_NOT_PERM;
        else if (cmd_op >= OP_ADD && cur_mode != 2'd0)          imm_code = RC_NOT_PERM;
        else if (cmd_op == OP_ADD && (cmd_mode == 2'd0 || cmd_mode == 2'd3))
                                                                imm_code = RC_BAD_OP;
        else if (cmd_op != OP_LOGOUT && cmd_op != OP_SETPW)     imm_scan = 1'b1;
    end

    // Final scan results merge the running first-hit/first-free with the last slot compared this cycle.
    always_comb begin
        scan_hit     = tbl_vld[scan_idx] && (tbl_name[scan_idx] == user_q);
        scan_last    = (scan_idx == IDX_W'(MAX_USERS - 1));
        scan_done    = (state == ST_SCAN) && scan_last;
        fin_hit      = hit_q || scan_hit;
        fin_idx      = hit_q ? hit_idx_q : scan_idx;
        fin_pw       = hit_q ? hit_pw_q : (tbl_pass[scan_idx] == pass_q);
        fin_free     = free_q || !tbl_vld[scan_idx];
        fin_free_idx = free_q ? free_idx_q : scan_idx;
        case (op_q)
            OP_LOGIN:  fin_code = !fin_hit ? RC_NO_USER : (fin_pw ? RC_OK : RC_BAD_PASS);
            OP_ADD:    fin_code = fin_hit ? RC_DUP : (fin_free ? RC_OK : RC_FULL);
            OP_CHANGE: fin_code = fin_hit ? RC_OK : RC_NO_USER;
            default:   fin_code = !fin_hit ? RC_NO_USER :
                                  ((fin_idx == '0 || fin_idx == cur_idx) ? RC_PROT : RC_OK);
        endcase
        alarm_set = scan_done && op_q == OP_LOGIN && fin_code != RC_OK &&
                    attempts == ATT_W'(MAX_ATTEMPTS - 1);
    end

`ifdef LOCKOUT_TIMER_EN
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
    logic [LK_W-1:0] lock_cnt;
    logic            lock_pend;
    assign lockout = (state == ST_LOCKOUT);
`else
    // Constant 0: the lockout timer is compiled out.
    assign lockout = (LOCKOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = imm_scan ? ST_SCAN : ST_RESP;
            end
            ST_SCAN: if (scan_last) state_nx = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_nx  = ST_IDLE;
`ifdef LOCKOUT_TIMER_EN
                if (lock_pend) state_nx = ST_LOCKOUT;
`endif
            end
`ifdef LOCKOUT_TIMER_EN
            ST_LOCKOUT: if (lock_cnt == LK_W'(LOCKOUT_CYCLES - 1)) state_nx = ST_IDLE;
`endif
            default: state_nx = ST_IDLE;
        endcase
        rsp_ok   = rsp_valid && (code_q == RC_OK);
        rsp_code = rsp_valid ? code_q : 3'd0;
    end

`ifdef LOCKOUT_TIMER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt  <= '0;
            lock_pend <= 1'b0;
        end else begin
            lock_cnt <= (state == ST_LOCKOUT) ? lock_cnt + 1'b1 : '0;
            if (alarm_set)             lock_pend <= 1'b1;
            else if (state == ST_RESP) lock_pend <= 1'b0;
        end
    end
`endif

    // Table, session and scan bookkeeping; all effects land on the edge into RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_USERS; i++) begin
                tbl_name[i] <= '0;
                tbl_pass[i] <= '0;
                tbl_mode[i] <= 2'd0;
            end
            tbl_vld     <= '0;
            tbl_vld[0]  <= 1'b1;
            tbl_name[0] <= ADMIN_NAME;
            tbl_pass[0] <= ADMIN_PASS;
            locked      <= 1'b1;
            cur_idx     <= '0;
            cur_mode    <= 2'd0;
            user_count  <= CNT_W'(1);
            alarm       <= 1'b0;
            attempts    <= '0;
            op_q        <= 3'd0;
            user_q      <= '0;
            pass_q      <= '0;
            mode_q      <= 2'd0;
            code_q      <= 3'd0;
            scan_idx    <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            hit_pw_q    <= 1'b0;
            free_q      <= 1'b0;
            free_idx_q  <= '0;
        end else begin
            if (alarm_set)      alarm <= 1'b1;
            else if (alarm_ack) alarm <= 1'b0;

            if (accept) begin
                op_q     <= cmd_op;
                user_q   <= cmd_user;
                pass_q   <= cmd_pass;
                mode_q   <= cmd_mode;
                code_q   <= imm_code;
                scan_idx <= '0;
                hit_q    <= 1'b0;
                free_q   <= 1'b0;
                if (!imm_scan && imm_code == RC_OK) begin
                    if (cmd_op == OP_LOGOUT) begin
                        locked <= 1'b1;
                        if (cur_mode == 2'd2) begin
                            tbl_vld[cur_idx]  <= 1'b0;
                            tbl_name[cur_idx] <= '0;
                            tbl_pass[cur_idx] <= '0;
                            tbl_mode[cur_idx] <= 2'd0;
                            user_count        <= user_count - 1'b1;
                        end
                    end else begin
                        tbl_pass[cur_idx] <= cmd_pass;
                    end
                end
            end else if (state == ST_SCAN) begin
                scan_idx <= scan_last ? '0 : scan_idx + 1'b1;
                if (scan_hit && !hit_q) begin
                    hit_q     <= 1'b1;
                    hit_idx_q <= scan_idx;
                    hit_pw_q  <= (tbl_pass[scan_idx] == pass_q);
                end
                if (!tbl_vld[scan_idx] && !free_q) begin
                    free_q     <= 1'b1;
                    free_idx_q <= scan_idx;
                end
                if (scan_last) begin
                    code_q <= fin_code;
                    case (op_q)
                        OP_LOGIN: begin
                            if (fin_code == RC_OK) begin
                                locked   <= 1'b0;
                                cur_idx  <= fin_idx;
                                cur_mode <= tbl_mode[fin_idx];
                                attempts <= '0;
                            end else begin
                                attempts <= alarm_set ? '0 : attempts + 1'b1;
                            end
                        end
                        OP_ADD: if (fin_code == RC_OK) begin
                            tbl_vld[fin_free_idx]  <= 1'b1;
                            tbl_name[fin_free_idx] <= user_q;
                            tbl_pass[fin_free_idx] <= pass_q;
                            tbl_mode[fin_free_idx] <= mode_q;
                            user_count             <= user_count + 1'b1;
                        end
                        OP_CHANGE: if (fin_code == RC_OK) tbl_pass[fin_idx] <= pass_q;
                        default: if (fin_code == RC_OK) begin
                            tbl_vld[fin_idx]  <= 1'b0;
                            tbl_name[fin_idx] <= '0;
                            tbl_pass[fin_idx] <= '0;
                            tbl_mode[fin_idx] <= 2'd0;
                            user_count        <= user_count - 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/auth_table_ctrl.md
Name: auth_table_ctrl

Overview:
- Parametrised successor to the single-table unlocker. It holds up to MAX_USERS credential entries (name and password of DIGITS digits of DIGIT_W bits), with admin, user and guest privilege modes.
- It serves login, logout and account-management commands through a valid/ready command port and a one-cycle response pulse.
- Table searches are sequential, one slot per cycle, and failed-login tracking drives a held alarm.
- It sits between the keypad/digit-entry front end and the display/alarm logic.

Parameters:
- DIGIT_W, 4, bits per digit
- DIGITS, 4, digits per name and per password; CRED_W = DIGIT_W*DIGITS
- MAX_USERS, 8, table slots (min 2)
- MAX_ATTEMPTS, 3, consecutive failed logins that raise the alarm
- LOCKOUT_CYCLES, 1000, lockout duration (used only with LOCKOUT_TIMER_EN)
- ADMIN_NAME, 16'h1100, slot 0 name after reset
- ADMIN_PASS, 16'h1100, slot 0 password after reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command can be accepted
- cmd_op  in  3  0 LOGIN, 1 LOGOUT, 2 SET_OWN_PW, 3 ADD_USER, 4 CHANGE_PW, 5 DELETE_USER, 6-7 reserved
- cmd_user  in  CRED_W  name operand
- cmd_pass  in  CRED_W  password operand
- cmd_mode  in  2  mode for ADD_USER (1 user, 2 guest)
- rsp_valid  out  1  one-cycle response pulse
- rsp_ok  out  1  command succeeded; qualified by rsp_valid
- rsp_code  out  3  0 OK, 1 BAD_PASS, 2 NO_USER, 3 NOT_PERMITTED, 4 TABLE_FULL, 5 DUPLICATE, 6 PROTECTED, 7 BAD_OP
- locked  out  1  no session active
- cur_idx  out  $clog2(MAX_USERS)  slot of the logged-in user
- cur_mode  out  2  0 admin, 1 user, 2 guest
- user_count  out  $clog2(MAX_USERS+1)  number of valid slots
- alarm  out  1  failed-attempt limit reached; held until acknowledged
- alarm_ack  in  1  clears alarm
- lockout  out  1  lockout timer running

Behaviour:
- **Reset values.** All slots are invalid and zeroed, except slot 0 = {ADMIN_NAME, ADMIN_PASS, mode 0, valid}. Outputs after reset: locked=1, cur_idx=0, cur_mode=0, user_count=1, alarm=0, lockout=0, rsp_*=0, cmd_ready=1. The attempt counter is 0.
- **Reset mid-operation.** Reset aborts any scan or lockout; no response is issued.
- **FSM states.** IDLE, SCAN, RESP, LOCKOUT. cmd_ready=1 only in IDLE. A command is accepted when cmd_valid && cmd_ready; operands are latched at acceptance.
- **Immediate commands.** Illegal or non-scan commands go IDLE->RESP: rsp_valid is asserted the cycle after acceptance. These are:
  - reserved op -> BAD_OP
  - any op other than LOGIN while locked -> NOT_PERMITTED
  - LOGIN while unlocked -> NOT_PERMITTED
  - guest issuing SET_OWN_PW -> NOT_PERMITTED
  - non-admin issuing ADD/CHANGE/DELETE -> NOT_PERMITTED
  - ADD with cmd_mode 0 or 3 -> BAD_OP
  - LOGOUT: sets locked=1; if cur_mode=2 the guest slot is invalidated (user_count-1) -> OK
  - SET_OWN_PW: writes the password of slot cur_idx -> OK
- **Scan commands.** LOGIN, ADD, CHANGE and DELETE go to SCAN.
  - Slot k is compared in cycle T+1+k, where T is the acceptance cycle.
  - rsp_valid is asserted exactly at T+MAX_USERS+1, whether or not a match occurred.
  - The lowest-index valid name match wins.
  - Table writes occur in the response cycle.
- **LOGIN.**
  - Name and password match: locked=0, cur_idx/cur_mode updated, attempts=0, OK.
  - Name match, wrong password -> BAD_PASS.
  - No name match -> NO_USER.
  - Both failures increment attempts. When attempts reaches MAX_ATTEMPTS: alarm=1 and attempts=0.
- **ADD_USER.**
  - Name already present -> DUPLICATE.
  - No free slot -> TABLE_FULL.
  - Otherwise the lowest free slot is written with the new entry and user_count+1 -> OK.
- **CHANGE_PW.** On name match, that slot's password is overwritten -> OK. Otherwise NO_USER.
- **DELETE_USER.**
  - Match at slot 0 or at cur_idx -> PROTECTED.
  - Other match: slot invalidated and zeroed, user_count-1 -> OK.
  - No match -> NO_USER.
- **Alarm.** If alarm_ack and a new alarm set occur in the same cycle, set wins. alarm does not block commands.
- **Widths.** Name and password comparisons are full CRED_W equality. user_count never exceeds MAX_USERS and never drops below 1.

Optional Feature:
- Macro: LOCKOUT_TIMER_EN.
- Defined: when the alarm is raised, the FSM enters LOCKOUT after RESP, with lockout=1 and cmd_ready=0, for exactly LOCKOUT_CYCLES cycles. It then returns to IDLE with lockout=0.
- Not defined: the lockout output is tied to 0, the LOCKOUT state and its counter are absent, and the FSM returns to IDLE after RESP.

Test Plan:
- Reset, then LOGIN(1100,1100) -> rsp_valid at T+9, OK, locked=0, cur_idx=0, cur_mode=0.
- As admin, ADD(2222,3333,mode 2) -> OK, user_count=2. LOGOUT, then LOGIN(2222,3333) -> OK, cur_mode=2. LOGOUT -> user_count=1, slot 1 invalid.
- Three LOGIN(1100,9999) -> BAD_PASS each; alarm=1 after the third. With LOCKOUT_TIMER_EN: cmd_ready=0 for exactly 1000 cycles. alarm_ack -> alarm=0.
- As admin, ADD until 8 users, then a 9th ADD -> TABLE_FULL. ADD of an existing name -> DUPLICATE.
- As admin, DELETE(1100) -> PROTECTED. DELETE of an absent name -> NO_USER. As user mode, DELETE -> NOT_PERMITTED at T+1.
- Assert rst during SCAN -> no rsp_valid, locked=1, user_count=1, slot 0 restored.
